adder4_feed_ctrl: RTL and testbench
===================================

# adder4_feed_ctrl

Operand feeder and result collector wrapped around the 4-bit ripple-carry adder datapath. Accepts operand pairs over a valid/ready input handshake and buffers them. Drives each pair onto the adder's A/B inputs, waits one full cycle for the carry chain to settle, then captures {C4,S} into a result register. The result is offered on a valid/ready output handshake. Sits between the chip I/O (ui_in) and the output pins (uo_out) of the tile, with the adder instantiated alongside it.

## Interface
- FIFO_DEPTH, 4, operand buffer entries; power of two, ≥2; used only when ADDER4_FEED_FIFO_EN is defined
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present on in_a/in_b
- in_ready  out  1  block can accept a pair this cycle
- in_a  in  4  operand A
- in_b  in  4  operand B
- add_a  out  4  to adder A input
- add_b  out  4  to adder B input
- add_s  in  4  adder sum
- add_c4  in  1  adder carry-out
- res_valid  out  1  res_data holds an unconsumed result
- res_ready  in  1  consumer accepts result
- res_data  out  5  {carry, sum}
- ovf_count  out  8  number of delivered results with carry=1, saturating
- busy  out  1  state≠IDLE or buffer non-empty

## Operation
- Push: in_valid & in_ready at an edge writes {in_a,in_b} to buffer tail. in_ready = !full, from registered occupancy only; no combinational path from res_ready or in_valid.
- FSM states: IDLE, EVAL, HOLD.
  - IDLE: if buffer non-empty → pop head into op_a/op_b, go EVAL; else stay.
  - EVAL: add_a/add_b show op_a/op_b. At the edge, capture res_data <= {add_c4,add_s}, res_valid <= 1, go HOLD.
  - HOLD: res_valid=1. On res_valid & res_ready: if buffer non-empty, pop the next pair into op regs, res_valid <= 0, go EVAL. Otherwise res_valid <= 0, go IDLE. Without a handshake, stay in HOLD with res_data stable.
- add_a/add_b are registered copies of op_a/op_b. They hold their last value in IDLE and HOLD and do not return to 0.
- ovf_count increments on each result handshake whose carry bit=1. It saturates at 255 and does not wrap.
- Simultaneous push and pop in the same cycle: both take effect; occupancy is unchanged.
- Push while full cannot occur because in_ready=0. A pop in the same cycle does not raise in_ready until the next cycle.
- Ordering is strict FIFO; each accepted pair produces exactly one result.

## Timing
- Reset values: in_ready=1, add_a=0, add_b=0, res_valid=0, res_data=0, ovf_count=0, busy=0. State is IDLE and the buffer is empty.
- Reset mid-operation: on the next edge all buffered pairs and any pending result are discarded and the outputs return to reset values.
- Latency, idle block: pair accepted at edge E0. It is popped at E1, with add_a/add_b valid after E1. Result is captured at E2, and res_valid is high from E2.
- Back-to-back throughput with res_ready held at 1: one result every 2 cycles.
- The adder combinational path has one full clock period from add_a/add_b update to capture.

## Configuration
- ADDER4_FEED_FIFO_EN defined: the operand buffer is a circular FIFO of FIFO_DEPTH entries with wrap-around pointers and a (log2(FIFO_DEPTH)+1)-bit count. full = count==FIFO_DEPTH.
- ADDER4_FEED_FIFO_EN undefined: the buffer is a single-entry register. full = entry occupied, and FIFO_DEPTH is ignored. All other behaviour and latency are identical.

## Test plan
- Reset then single add: push A=4'h3, B=4'h4 → at E2 res_valid=1, res_data=5'h07. Handshake → ovf_count=0, busy=0.
- Carry: push A=4'hF, B=4'h1 → res_data=5'h10. After handshake, ovf_count=1. Push A=F, B=F → res_data=5'h1E, ovf_count=2.
- Backpressure/full (FIFO_EN, depth 4): hold res_ready=0 and push 6 pairs (i, i+1 for i=0..5).
  - Required: 5 pairs are accepted (1 in HOLD, 4 buffered), then in_ready=0.
  - Release res_ready → results 1,3,5,7,9,11 delivered in order. in_ready rises the cycle after the first buffered pop.
- Wrap and simultaneous push/pop: stream 20 random pairs with in_valid=1 and res_ready=1 → all 20 results correct, in order, and the count never exceeds 4.
- Saturation: deliver 260 carry results (A=F, B=1) → ovf_count stays at 255.
- Reset mid-operation: buffer 3 pairs, assert rst for one cycle → all outputs at reset values and no stale result appears. A fresh push of A=2, B=2 yields res_data=5'h04.

Source files
------------

// File: rtl/adder4_feed_ctrl_if.sv
// adder4_feed_ctrl_if: operand/result handshakes plus the adder A/B/S/C4 hookup
// slave  : controller view (accepts operands, drives adder inputs, offers results)
// master : environment view (chip I/O side and the 4-bit adder itself)
interface adder4_feed_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_s;
  logic       add_c4;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_data;
  modport master (
    output in_valid, in_a, in_b, add_s, add_c4, res_ready,
    input  in_ready, add_a, add_b, res_valid, res_data
  );
  modport slave (
    input  in_valid, in_a, in_b, add_s, add_c4, res_ready,
    output in_ready, add_a, add_b, res_valid, res_data
  );
endinterface

// File: rtl/adder4_feed_ctrl.sv
// adder4_feed_ctrl: buffers operand pairs, feeds the ripple adder, collects {C4,S} results
// Ports: clk, rst (sync active-high); bus (slave modport: in_* operand handshake,
// add_* adder hookup, res_* result handshake); ovf_count (saturating carry-result
// count); busy (FSM active or buffer non-empty).
// Option: ADDER4_FEED_FIFO_EN selects a FIFO_DEPTH-entry circular buffer;
// otherwise the buffer is a single register.
module adder4_feed_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  adder4_feed_ctrl_if.slave     bus,
  output logic [7:0]            ovf_count,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
  state_t     state_q;
  logic [3:0] add_a_q, add_b_q;
  logic       res_valid_q;
  logic [4:0] res_data_q;
  logic [7:0] ovf_q;
  logic       full, empty, push, pop;
  logic [7:0] head;
  assign push = bus.in_valid && !full;
  // HOLD implies res_valid, so a handshake there reduces to res_ready
  assign pop  = !empty && (state_q == IDLE || (state_q == HOLD && bus.res_ready));
`ifdef ADDER4_FEED_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {bus.in_a, bus.in_b};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`else
  logic [7:0] ent_q;
  logic       occ_q;
  logic       unused_depth;
  assign unused_depth = ^FIFO_DEPTH;
  assign full  = occ_q;
  assign empty = !occ_q;
  assign head  = ent_q;
  // push needs an empty slot and pop needs an occupied one, so they never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
      occ_q <= 1'b0;
    end else begin
      if (push) ent_q <= {bus.in_a, bus.in_b};
      occ_q <= push || (occ_q && !pop);
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      ovf_q       <= '0;
    end else begin
      if (pop) {add_a_q, add_b_q} <= head;
      case (state_q)
        IDLE: if (!empty) state_q <= EVAL;
        EVAL: begin
          res_data_q  <= {bus.add_c4, bus.add_s};
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= empty ? IDLE : EVAL;
          if (res_data_q[4] && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = !full;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign ovf_count     = ovf_q;
  assign busy          = state_q != IDLE || !empty;
endmodule

// File: tb/tb_adder4_feed_ctrl.sv
// tb_adder4_feed_ctrl: directed + random checks of adder4_feed_ctrl against a queue model
module tb_adder4_feed_ctrl;
`ifdef ADDER4_FEED_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ovf_count;
  logic       busy;
  int n_chk = 0, n_fail = 0, n_deliv = 0, n_carry = 0;
  logic [4:0] exp_q [$];

  adder4_feed_ctrl_if bus ();
  adder4_feed_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .ovf_count(ovf_count), .busy(busy)
  );
  assign {bus.add_c4, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s got=timeout exp=event", tag);
  endtask

  // Transaction model: every accepted pair queues its sum; every delivered result must match the head.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      n_carry = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) fail_now("spurious_result");
        else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("result", bus.res_data, e);
          if (e[4]) n_carry++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({1'b0, bus.in_a} + {1'b0, bus.in_b});
        chk("outstanding_le_cap", 32'(exp_q.size() <= CAP + 1), 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_in_ready"}, bus.in_ready, 1);
    chk({p, "_add_a"}, bus.add_a, 0);
    chk({p, "_add_b"}, bus.add_b, 0);
    chk({p, "_res_valid"}, bus.res_valid, 0);
    chk({p, "_res_data"}, bus.res_data, 0);
    chk({p, "_ovf"}, ovf_count, 0);
    chk({p, "_busy"}, busy, 0);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int k = 0;
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    do begin
      ok = bus.in_ready;
      step();
      k++;
    end while (!ok && k < 200);
    if (!ok) fail_now("send");
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int k = 0;
    while (!bus.res_valid && k < 200) begin
      step();
      k++;
    end
    if (!bus.res_valid) fail_now("wait_res");
  endtask

  task automatic drain(input int n);
    int target = n_deliv + n;
    int k = 0;
    bus.res_ready = 1'b1;
    while (n_deliv < target && k < 2000) begin
      step();
      k++;
    end
    if (n_deliv < target) fail_now("drain");
    bus.res_ready = 1'b0;
  endtask

  task automatic stream(input int n, input bit rnd);
    int got = 0;
    int k = 0;
    logic ok;
    bus.res_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = rnd ? 4'($urandom) : 4'hF;
    bus.in_b = rnd ? 4'($urandom) : 4'h1;
    while (got < n && k < 4 * n + 50) begin
      ok = bus.in_ready;
      step();
      k++;
      if (ok) begin
        got++;
        bus.in_a = rnd ? 4'($urandom) : 4'hF;
        bus.in_b = rnd ? 4'($urandom) : 4'h1;
      end
    end
    bus.in_valid = 1'b0;
    chk("stream_accepted", got, n);
    drain(exp_q.size());
    chk("stream_drained", exp_q.size(), 0);
  endtask

  initial begin
    int acc, k;
    logic ok;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("rst");
    // latency from an idle block
    bus.in_valid = 1'b1;
    bus.in_a = 4'h3;
    bus.in_b = 4'h4;
    step();
    bus.in_valid = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_res_valid", bus.res_valid, 0);
    step();
    chk("e1_add_a", bus.add_a, 4'h3);
    chk("e1_add_b", bus.add_b, 4'h4);
    chk("e1_res_valid", bus.res_valid, 0);
    step();
    chk("e2_res_valid", bus.res_valid, 1);
    chk("e2_res_data", bus.res_data, 5'h07);
    drain(1);
    chk("single_ovf", ovf_count, 0);
    chk("single_busy", busy, 0);
    chk("single_res_valid", bus.res_valid, 0);
    // carry results
    send(4'hF, 4'h1);
    wait_res();
    chk("carry_data", bus.res_data, 5'h10);
    drain(1);
    chk("carry_ovf1", ovf_count, 1);
    send(4'hF, 4'hF);
    wait_res();
    chk("carry_data2", bus.res_data, 5'h1E);
    chk("carry_add_a_hold", bus.add_a, 4'hF);
    drain(1);
    chk("carry_ovf2", ovf_count, 2);
    // backpressure until the buffer fills
    acc = 0;
    k = 0;
    while (acc < 6 && k < 20) begin
      bus.in_valid = 1'b1;
      bus.in_a = 4'(acc);
      bus.in_b = 4'(acc + 1);
      ok = bus.in_ready;
      step();
      if (ok) acc++;
      k++;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", acc, CAP + 1);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_res_valid", bus.res_valid, 1);
    chk("bp_res_data", bus.res_data, 5'h01);
    bus.res_ready = 1'b1;
    step();
    chk("bp_in_ready_rise", bus.in_ready, 1);
    chk("bp_res_valid_drop", bus.res_valid, 0);
    drain(acc - 1);
    for (int i = acc; i < 6; i++) begin
      send(4'(i), 4'(i + 1));
      drain(1);
    end
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_ovf", ovf_count, 2);
    // random back-to-back stream with wrap-around
    stream(20, 1'b1);
    chk("stream_ovf_model", ovf_count, n_carry > 255 ? 255 : n_carry);
    // saturation
    stream(260, 1'b0);
    chk("sat_ovf", ovf_count, 255);
    // reset with work in flight
    for (int i = 0; i < (CAP + 1 < 3 ? CAP + 1 : 3); i++) send(4'(i + 1), 4'(i + 5));
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("mid");
    repeat (4) step();
    chk("mid_no_stale", bus.res_valid, 0);
    chk("mid_idle", busy, 0);
    send(4'h2, 4'h2);
    wait_res();
    chk("mid_fresh", bus.res_data, 5'h04);
    drain(1);
    chk("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
